// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with freeze hold, flush/hazard bubble insertion and a valid flag.
// Optional performance counters are enabled with `define ID_EXE_PERF_CNT_EN.
module id_exe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              hazard,
    input  logic              WB_EN_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic              B_in,
    input  logic              S_in,
    input  logic [3:0]        EXE_CMD_in,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [DATA_W-1:0] Val_Rn_in,
    input  logic [DATA_W-1:0] Val_Rm_in,
    input  logic              Imm_in,
    input  logic [11:0]       Shift_operand_in,
    input  logic [IMM_W-1:0]  Signed_imm_in,
    input  logic [3:0]        Dest_in,
    input  logic [3:0]        Src1_in,
    input  logic [3:0]        Src2_in,
    input  logic [3:0]        SR_in,
    output logic              WB_EN_out,
    output logic              MEM_R_EN_out,
    output logic              MEM_W_EN_out,
    output logic              B_out,
    output logic              S_out,
    output logic [3:0]        EXE_CMD_out,
    output logic [DATA_W-1:0] PC_out,
    output logic [DATA_W-1:0] Val_Rn_out,
    output logic [DATA_W-1:0] Val_Rm_out,
    output logic              Imm_out,
    output logic [11:0]       Shift_operand_out,
    output logic [IMM_W-1:0]  Signed_imm_out,
    output logic [3:0]        Dest_out,
    output logic [3:0]        Src1_out,
    output logic [3:0]        Src2_out,
    output logic [3:0]        SR_out,
    output logic              valid_out
`ifdef ID_EXE_PERF_CNT_EN
    ,
    output logic [15:0]       freeze_cnt,
    output logic [15:0]       flush_cnt,
    output logic [15:0]       hazard_cnt
`endif
);

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              b;
        logic              s;
        logic [3:0]        exe_cmd;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic              imm;
        logic [11:0]       shift_operand;
        logic [IMM_W-1:0]  signed_imm;
        logic [3:0]        dest;
        logic [3:0]        src1;
        logic [3:0]        src2;
        logic [3:0]        sr;
    } slot_t;

    slot_t slot_d;
    slot_t slot_q;
    logic  valid_q;

    assign slot_d = '{
        wb_en:         WB_EN_in,
        mem_r_en:      MEM_R_EN_in,
        mem_w_en:      MEM_W_EN_in,
        b:             B_in,
        s:             S_in,
        exe_cmd:       EXE_CMD_in,
        pc:            PC_in,
        val_rn:        Val_Rn_in,
        val_rm:        Val_Rm_in,
        imm:           Imm_in,
        shift_operand: Shift_operand_in,
        signed_imm:    Signed_imm_in,
        dest:          Dest_in,
        src1:          Src1_in,
        src2:          Src2_in,
        sr:            SR_in
    };

    // A bubble is an all-zero slot, so Execute sees deterministic contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q  <= '0;
            valid_q <= 1'b0;
        end else if (freeze) begin
            slot_q  <= slot_q;
            valid_q <= valid_q;
        end else if (flush || hazard) begin
            slot_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            valid_q <= 1'b1;
        end
    end

    assign WB_EN_out         = slot_q.wb_en;
    assign MEM_R_EN_out      = slot_q.mem_r_en;
    assign MEM_W_EN_out      = slot_q.mem_w_en;
    assign B_out             = slot_q.b;
    assign S_out             = slot_q.s;
    assign EXE_CMD_out       = slot_q.exe_cmd;
    assign PC_out            = slot_q.pc;
    assign Val_Rn_out        = slot_q.val_rn;
    assign Val_Rm_out        = slot_q.val_rm;
    assign Imm_out           = slot_q.imm;
    assign Shift_operand_out = slot_q.shift_operand;
    assign Signed_imm_out    = slot_q.signed_imm;
    assign Dest_out          = slot_q.dest;
    assign Src1_out          = slot_q.src1;
    assign Src2_out          = slot_q.src2;
    assign SR_out            = slot_q.sr;
    assign valid_out         = valid_q;

`ifdef ID_EXE_PERF_CNT_EN
    // At most one counter moves per edge, in the same priority as the register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freeze_cnt <= '0;
            flush_cnt  <= '0;
            hazard_cnt <= '0;
        end else if (freeze) begin
            if (freeze_cnt != 16'hFFFF) freeze_cnt <= freeze_cnt + 16'd1;
        end else if (flush) begin
            if (flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end else if (hazard) begin
            if (hazard_cnt != 16'hFFFF) hazard_cnt <= hazard_cnt + 16'd1;
        end
    end
`endif

endmodule
